// File: rtl/rx_pkt_fifo.sv
// rx_pkt_fifo: first-word-fall-through receive FIFO with occupancy flags
// and sticky overflow/underflow indicators.
// Optional build macro RX_PKT_ROLLBACK_EN adds packet commit/discard:
// writes land speculatively and only become readable on pkt_commit.
module rx_pkt_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 64,
    parameter int AF_THRESH = DEPTH - 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     w_enable,
    input  logic [DATA_W-1:0]        w_data,
    input  logic                     r_enable,
`ifdef RX_PKT_ROLLBACK_EN
    input  logic                     pkt_commit,
    input  logic                     pkt_discard,
`endif
    output logic [DATA_W-1:0]        r_data,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] AF_P    = PW'(AF_THRESH);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    logic [DATA_W-1:0] mem [DEPTH];

    // wr_ptr is the write-side (speculative) pointer; vis_ptr bounds what
    // the read side may see. Without rollback the two are the same.
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] vis_ptr;
    logic [PW-1:0] wr_cnt;
    logic          wr_ok;
    logic          rd_ok;

`ifdef RX_PKT_ROLLBACK_EN
    logic [PW-1:0] cmt_ptr;
    assign vis_ptr = cmt_ptr;
`else
    assign vis_ptr = wr_ptr;
`endif

    // Flags come only from registered pointers.
    assign count       = vis_ptr - rd_ptr;
    assign wr_cnt      = wr_ptr - rd_ptr;
    assign empty       = (count == '0);
    assign full        = (wr_cnt == DEPTH_P);
    assign almost_full = (count >= AF_P);
    assign r_data      = mem[rd_ptr[AW-1:0]];

    // A pop frees the head slot, so a write is allowed while full if a
    // read happens in the same cycle.
    assign rd_ok = r_enable && !empty;
    assign wr_ok = w_enable && (!full || rd_ok);

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_ok && !flush) begin
            mem[wr_ptr[AW-1:0]] <= w_data;
        end
    end

    // Pointer and sticky-flag update; flush overrides all traffic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
`ifdef RX_PKT_ROLLBACK_EN
            cmt_ptr   <= '0;
`endif
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
`ifdef RX_PKT_ROLLBACK_EN
            cmt_ptr   <= '0;
`endif
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (rd_ok) begin
                rd_ptr <= rd_ptr + ONE_P;
            end
            if (w_enable && !wr_ok) begin
                overflow <= 1'b1;
            end
            if (r_enable && empty) begin
                underflow <= 1'b1;
            end
`ifdef RX_PKT_ROLLBACK_EN
            if (pkt_discard) begin
                wr_ptr <= cmt_ptr;
            end else begin
                if (wr_ok) begin
                    wr_ptr <= wr_ptr + ONE_P;
                end
                if (pkt_commit) begin
                    cmt_ptr <= wr_ptr + {{(PW-1){1'b0}}, wr_ok};
                end
            end
`else
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ONE_P;
            end
`endif
        end
    end

endmodule

// File: tb/tb_rx_pkt_fifo.sv
// Testbench for rx_pkt_fifo (DEPTH=8, AF_THRESH=6, DATA_W=8): directed
// scenarios with literal expectations plus randomized traffic compared
// every cycle against a queue-based model.
module tb_rx_pkt_fifo;

    localparam int DEPTH = 8;
    localparam int AFT   = 6;
`ifdef RX_PKT_ROLLBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       w_enable = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic       r_enable = 1'b0;
`ifdef RX_PKT_ROLLBACK_EN
    logic       pkt_commit = 1'b0;
    logic       pkt_discard = 1'b0;
`endif
    logic [7:0] r_data;
    logic       empty, full, almost_full, overflow, underflow;
    logic [3:0] count;

    int checks = 0;
    int failures = 0;

    // Model: q holds readable words, sq holds written-but-uncommitted words.
    logic [7:0] q[$];
    logic [7:0] sq[$];
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    rx_pkt_fifo #(.DATA_W(8), .DEPTH(DEPTH), .AF_THRESH(AFT)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .w_enable(w_enable), .w_data(w_data), .r_enable(r_enable),
`ifdef RX_PKT_ROLLBACK_EN
        .pkt_commit(pkt_commit), .pkt_discard(pkt_discard),
`endif
        .r_data(r_data), .empty(empty), .full(full),
        .almost_full(almost_full), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        sq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input bit we, input logic [7:0] wd, input bit re,
                              input bit fl, input bit cm, input bit ds);
        bit rd_ok, wr_ok, is_full, c, d;
        c = RB ? cm : 1'b1;
        d = RB ? ds : 1'b0;
        if (fl) begin
            model_reset();
            return;
        end
        is_full = (q.size() + sq.size()) == DEPTH;
        rd_ok = re && (q.size() > 0);
        if (re && q.size() == 0) m_unf = 1'b1;
        wr_ok = we && (!is_full || rd_ok);
        if (we && !wr_ok) m_ovf = 1'b1;
        if (rd_ok) void'(q.pop_front());
        if (d) begin
            sq.delete();
        end else begin
            if (wr_ok) sq.push_back(wd);
            if (c) begin
                while (sq.size() > 0) q.push_back(sq.pop_front());
            end
        end
    endtask

    task automatic compare_all();
        chk("empty", empty, q.size() == 0);
        chk("count", count, q.size());
        chk("full", full, (q.size() + sq.size()) == DEPTH);
        chk("almost_full", almost_full, q.size() >= AFT);
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_unf);
        if (q.size() > 0) chk("r_data", r_data, q[0]);
    endtask

    task automatic cyc(input bit we, input logic [7:0] wd, input bit re,
                       input bit fl, input bit cm, input bit ds);
        w_enable = we;
        w_data   = wd;
        r_enable = re;
        flush    = fl;
`ifdef RX_PKT_ROLLBACK_EN
        pkt_commit  = cm;
        pkt_discard = ds;
`endif
        @(posedge clk);
        model_step(we, wd, re, fl, cm, ds);
        #1;
        compare_all();
    endtask

    initial begin
        logic [7:0] popped[$];
        bit we, re, fl, cm, ds;
        int phase;

        // Reset state, checked while rst is still high.
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        #10 rst = 1'b0;
        model_reset();

        // Fill with 0x11..0x18; almost_full from the 6th write on.
        for (int i = 0; i < 8; i++) begin
            cyc(1, 8'(8'h11 + i), 0, 0, RB, 0);
            chk("fill_af", almost_full, i >= 5);
        end
        chk("fill_full", full, 1);
        chk("fill_count", count, 8);
        cyc(1, 8'h99, 0, 0, RB, 0);
        chk("fill_ovf", overflow, 1);
        chk("fill_count9", count, 8);

        // Drain in order, then one read on empty.
        for (int i = 0; i < 8; i++) begin
            chk("drain_data", r_data, 8'(8'h11 + i));
            cyc(0, 8'h00, 1, 0, 0, 0);
        end
        chk("drain_empty", empty, 1);
        cyc(0, 8'h00, 1, 0, 0, 0);
        chk("drain_unf", underflow, 1);
        chk("drain_count", count, 0);

        // Wrap twice: 20 words through, reading once at least 3 are held.
        cyc(0, 8'h00, 0, 1, 0, 0);
        popped.delete();
        for (int i = 0; i < 26; i++) begin
            re = (count >= 3) || (i >= 20);
            if (re && !empty) popped.push_back(r_data);
            cyc(i < 20, 8'(8'h40 + i), re, 0, RB, 0);
        end
        chk("wrap_num", popped.size(), 20);
        for (int i = 0; i < popped.size(); i++) chk("wrap_order", popped[i], 8'(8'h40 + i));

        // Simultaneous push/pop while full, then while empty.
        cyc(0, 8'h00, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) cyc(1, 8'(8'h11 + i), 0, 0, RB, 0);
        chk("rw_full_head", r_data, 8'h11);
        cyc(1, 8'hA5, 1, 0, RB, 0);
        chk("rw_full_count", count, 8);
        chk("rw_full_ovf", overflow, 0);
        chk("rw_full_next", r_data, 8'h12);
        for (int i = 0; i < 7; i++) cyc(0, 8'h00, 1, 0, 0, 0);
        chk("rw_full_last", r_data, 8'hA5);
        cyc(0, 8'h00, 1, 0, 0, 0);
        chk("rw_empty_pre", count, 0);
        cyc(1, 8'h3C, 1, 0, RB, 0);
        chk("rw_empty_unf", underflow, 1);
        chk("rw_empty_count", count, 1);

        // Flush with count=3 and overflow set; concurrent write dropped.
        cyc(0, 8'h00, 0, 1, 0, 0);
        for (int i = 0; i < 9; i++) cyc(1, 8'(8'h20 + i), 0, 0, RB, 0);
        for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1, 0, 0, 0);
        chk("fl_pre_count", count, 3);
        chk("fl_pre_ovf", overflow, 1);
        cyc(1, 8'hEE, 0, 1, RB, 0);
        chk("fl_count", count, 0);
        chk("fl_empty", empty, 1);
        chk("fl_ovf", overflow, 0);
        cyc(1, 8'h77, 0, 0, RB, 0);
        chk("fl_after", r_data, 8'h77);
        chk("fl_after_count", count, 1);

`ifdef RX_PKT_ROLLBACK_EN
        // Commit makes a packet visible; discard rewinds to the last commit.
        cyc(0, 8'h00, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 8'(8'hA1 + i), 0, 0, 0, 0);
        chk("rb_hidden", empty, 1);
        cyc(0, 8'h00, 0, 0, 1, 0);
        chk("rb_commit", count, 3);
        cyc(1, 8'hB1, 0, 0, 0, 0);
        cyc(1, 8'hB2, 0, 0, 0, 1);
        chk("rb_discard", count, 3);
        cyc(1, 8'hC1, 0, 0, 1, 0);
        chk("rb_count4", count, 4);
        popped.delete();
        for (int i = 0; i < 4; i++) begin
            popped.push_back(r_data);
            cyc(0, 8'h00, 1, 0, 0, 0);
        end
        chk("rb_w0", popped[0], 8'hA1);
        chk("rb_w2", popped[2], 8'hA3);
        chk("rb_w3", popped[3], 8'hC1);
`endif

        // Randomized traffic alternating write-heavy and read-heavy phases.
        for (int i = 0; i < 1600; i++) begin
            phase = (i / 100) % 2;
            we = $urandom_range(0, 99) < (phase == 0 ? 75 : 35);
            re = $urandom_range(0, 99) < (phase == 0 ? 35 : 75);
            fl = $urandom_range(0, 99) < 2;
            cm = $urandom_range(0, 99) < 25;
            ds = $urandom_range(0, 99) < 5;
            cyc(we, 8'($urandom), re, fl, cm, ds);
        end

        // Asynchronous reset mid-operation, including uncommitted data.
        cyc(0, 8'h00, 0, 1, 0, 0);
        cyc(1, 8'h01, 0, 0, RB, 0);
        cyc(1, 8'h02, 0, 0, 1, 0);
        cyc(1, 8'h03, 0, 0, 0, 0);
        #3 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_full", full, 0);
        #2 rst = 1'b0;
        cyc(1, 8'h5A, 0, 0, RB, 0);
        chk("arst_first", r_data, 8'h5A);
        chk("arst_count1", count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_pkt_fifo.md
RX_PKT_FIFO -- requirements
Module: rx_pkt_fifo

Interface
REQ-001 Parameter DATA_W, default 8, width of each stored word.
REQ-002 Parameter DEPTH, default 64, number of entries; power of two, minimum 4.
REQ-003 Parameter AF_THRESH, default DEPTH-4, occupancy at or above which almost_full asserts.
REQ-004 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  in  1  reset, asynchronous, active-high.
REQ-006 Port flush  in  1  synchronous clear of all contents and sticky flags.
REQ-007 Port w_enable  in  1  push w_data this cycle.
REQ-008 Port w_data  in  DATA_W  write word.
REQ-009 Port r_enable  in  1  pop head word this cycle.
REQ-010 Port r_data  out  DATA_W  head word, first-word fall-through.
REQ-011 Port empty  out  1  no readable (committed) word.
REQ-012 Port full  out  1  no free entry.
REQ-013 Port almost_full  out  1  readable count >= AF_THRESH.
REQ-014 Port count  out  clog2(DEPTH)+1  number of readable words, 0..DEPTH.
REQ-015 Port overflow  out  1  sticky: write attempted while full.
REQ-016 Port underflow  out  1  sticky: read attempted while empty.
REQ-017 Ports pkt_commit, pkt_discard  in  1 each  present only with RX_PKT_ROLLBACK_EN (see REQ-033).

Function
REQ-018 Storage: DEPTH x DATA_W array; read and write pointers clog2(DEPTH)+1 bits, wrap modulo 2*DEPTH; MSB distinguishes full from empty.
REQ-019 Write: w_enable and not full at clock edge -> word stored at write pointer, pointer +1.
REQ-020 Read: r_enable and not empty at clock edge -> read pointer +1; r_data presents the next word in the following cycle.
REQ-021 r_data always equals the word at the read pointer; its value while empty is don't-care.
REQ-022 Latency: a word written at edge N is visible (empty=0, count updated) from edge N onward, i.e. readable in cycle N+1; no same-cycle write-to-read bypass.
REQ-023 Write while full: word dropped, pointers unchanged, overflow set.
REQ-024 Read while empty: no pointer change, underflow set; this applies even if w_enable is asserted in the same cycle.
REQ-025 Simultaneous read and write while full: both performed, count unchanged, overflow not set.
REQ-026 Simultaneous read and write with 0<count<DEPTH: both performed, count unchanged.
REQ-027 Pointers wrap from entry DEPTH-1 to 0 with no gap and no data corruption.
REQ-028 flush has priority over all reads and writes: at the edge, all pointers are set to 0 and overflow/underflow are cleared; concurrent w_enable and r_enable are ignored.
REQ-029 count, full, empty and almost_full are registered or derived only from registered pointers, with no combinational path from w_enable or r_enable.

Reset
REQ-030 rst asserted: all pointers become 0 immediately; empty=1, full=0, almost_full=0 (unless AF_THRESH=0), count=0, overflow=0, underflow=0.
REQ-031 Storage array contents are not reset.
REQ-032 Reset mid-operation discards all contents, including uncommitted packet data; the first write after rst deasserts is accepted normally.

Configuration
REQ-033 Macro RX_PKT_ROLLBACK_EN defined: the block keeps a speculative write pointer and a committed write pointer.
  - Writes advance the speculative pointer only.
  - empty, count, almost_full and read-side visibility use the committed pointer.
  - full uses the speculative pointer.
  - pkt_commit copies the speculative pointer to the committed pointer, including any write accepted in the same cycle.
  - pkt_discard restores the speculative pointer from the committed pointer and drops any same-cycle write.
  - pkt_discard wins over pkt_commit; flush wins over both.
REQ-034 Macro undefined: pkt_commit and pkt_discard ports are absent; every accepted write is immediately committed (behaviour per REQ-019..REQ-029).

Verification (DEPTH=8, AF_THRESH=6, DATA_W=8)
REQ-035 After rst, write 0x11..0x18 on 8 consecutive cycles -> full=1, count=8, almost_full=1 from the 6th write; a 9th write of 0x99 -> overflow=1, 0x99 never read.
REQ-036 Drain a full FIFO -> r_data sequence 0x11..0x18 in order, then empty=1; a further r_enable -> underflow=1, count stays 0.
REQ-037 Run 20 writes interleaved with reads so the pointers wrap twice -> output order matches input order, no lost or duplicated words.
REQ-038 With count=8, assert w_enable=0xA5 and r_enable together -> 0x11 is popped, 0xA5 is stored, count=8, overflow=0; with count=0, assert both -> underflow=1, count=1.
REQ-039 With count=3 and overflow=1, assert flush together with w_enable -> count=0, empty=1, overflow=0, written word discarded.
REQ-040 With RX_PKT_ROLLBACK_EN: write 3 words -> empty stays 1; pkt_commit -> count=3; write 2 more then pkt_discard -> count=3 and a subsequent write lands directly after the 3rd word.
